// File: rtl/fetch_controller.sv
// Instruction fetch front end: owns the PC, runs a one-outstanding imem handshake
// and holds the fetched word for decode. Jumps and branches redirect the PC and squash stale fetches.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

  state_t      state;
  logic        redirect_pending;
  logic        redirect;
  logic [31:0] target;

  assign redirect = jump | branch;
  assign target   = {(jump ? jump_target[31:2] : branch_target[31:2]), 2'b00};

  // Outputs decode from state; gating with reset keeps them quiet while reset is held.
  assign imem_req  = (state == REQ) & ~reset;
  assign if_valid  = (state == HOLD) & ~reset;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= REQ;
      pc               <= RESET_PC;
      redirect_pending <= 1'b0;
      if_pc            <= 32'h0;
      if_instr         <= 32'h0;
    end else begin
      case (state)
        REQ: begin
          if (imem_gnt) begin
            state <= WAIT;
            // A redirect in the grant cycle makes the just-issued fetch stale.
            if (redirect) begin
              pc               <= target;
              redirect_pending <= 1'b1;
            end
          end else if (redirect) begin
            pc <= target;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (redirect_pending | redirect) begin
              redirect_pending <= 1'b0;
              if (redirect) pc <= target;
              state <= REQ;
            end else begin
              if_instr <= imem_rdata;
              if_pc    <= pc;
              pc       <= pc + PC_STEP;
              state    <= HOLD;
            end
          end else if (redirect) begin
            pc               <= target;
            redirect_pending <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= REQ;
          end else if (if_ready) begin
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a transaction-level model (outstanding-fetch queue,
// held-instruction slot) checked every cycle, plus literal expectations at key points.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch = 1'b0, jump = 1'b0;
  logic [31:0] branch_target = 32'h0, jump_target = 32'h0;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_ready = 1'b1;

  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_instr, pc;
  logic        imem_req1, if_valid1;
  logic [31:0] imem_addr1, if_pc1, if_instr1, pc1;

  int checks = 0;
  int passed = 0;

  localparam logic [31:0] RST_PC0 = 32'h0000_0000;
  localparam logic [31:0] RST_PC1 = 32'hFFFF_FFFC;

  fetch_controller #(.RESET_PC(RST_PC0), .PC_STEP(32'd4)) dut (
    .clk(clk), .reset(reset), .branch(branch), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready), .pc(pc));

  fetch_controller #(.RESET_PC(RST_PC1), .PC_STEP(32'd4)) dut_wrap (
    .clk(clk), .reset(reset), .branch(branch), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .imem_req(imem_req1), .imem_addr(imem_addr1),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid1), .if_pc(if_pc1), .if_instr(if_instr1), .if_ready(if_ready), .pc(pc1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model of the front end.
  typedef struct {logic [31:0] addr; bit stale;} fetch_t;
  fetch_t      outq[$];
  bit          held = 0;
  logic [31:0] m_pc = RST_PC0, m_if_pc = 32'h0, m_if_instr = 32'h0;

  always @(posedge clk) begin
    bit          redir;
    logic [31:0] tgt;
    fetch_t      f;
    redir = jump | branch;
    tgt   = (jump ? jump_target : branch_target) & ~32'h3;
    if (reset) begin
      outq.delete();
      held = 0; m_pc = RST_PC0; m_if_pc = 32'h0; m_if_instr = 32'h0;
    end else if (held) begin
      if (redir) begin held = 0; m_pc = tgt; end
      else if (if_ready) held = 0;
    end else if (outq.size() != 0) begin
      if (imem_rvalid) begin
        f = outq.pop_front();
        if (f.stale || redir) begin
          if (redir) m_pc = tgt;
        end else begin
          held = 1; m_if_pc = f.addr; m_if_instr = imem_rdata; m_pc = m_pc + 32'd4;
        end
      end else if (redir) begin
        outq[0].stale = 1; m_pc = tgt;
      end
    end else begin
      if (imem_gnt) outq.push_back('{addr: m_pc, stale: redir});
      if (redir) m_pc = tgt;
    end
  end

  always @(negedge clk) begin
    check("model imem_req", {31'h0, imem_req}, {31'h0, !reset && outq.size() == 0 && !held});
    check("model if_valid", {31'h0, if_valid}, {31'h0, held && !reset});
    check("model pc", pc, m_pc);
    check("model imem_addr", imem_addr, m_pc);
    check("model if_pc", if_pc, m_if_pc);
    check("model if_instr", if_instr, m_if_instr);
  end

  task automatic tick();
    @(posedge clk); #1;
    imem_gnt = 0; imem_rvalid = 0; branch = 0; jump = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick(); tick();
    check("reset pc", pc, RST_PC0);
    check("reset imem_req", {31'h0, imem_req}, 32'h0);
    reset = 0;
  endtask

  // Grant now, data next cycle; leaves the DUT holding the word.
  task automatic fetch(input logic [31:0] data);
    imem_gnt = 1; tick();
    imem_rvalid = 1; imem_rdata = data; tick();
  endtask

  logic [31:0] seq_data [3] = '{32'h1111_0000, 32'h2222_0004, 32'h3333_0008};

  initial begin
    @(posedge clk); #1;

    // Sequential fetches with immediate grant/rvalid/ready.
    if_ready = 1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check("seq addr", imem_addr, 32'(4 * i));
      fetch(seq_data[i]);
      check("seq if_valid", {31'h0, if_valid}, 32'h1);
      check("seq if_pc", if_pc, 32'(4 * i));
      check("seq if_instr", if_instr, seq_data[i]);
      tick();
    end

    // Decode stall in HOLD.
    do_reset();
    if_ready = 0;
    fetch(32'hA0A0_0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall if_valid", {31'h0, if_valid}, 32'h1);
      check("stall if_instr", if_instr, 32'hA0A0_0000);
      check("stall imem_req", {31'h0, imem_req}, 32'h0);
    end
    if_ready = 1; tick();
    check("stall next req", {31'h0, imem_req}, 32'h1);
    check("stall next addr", imem_addr, 32'h4);

    // Branch while waiting for data at pc 0x8.
    do_reset();
    fetch(32'h0); tick();
    fetch(32'h4); tick();
    check("br addr before", imem_addr, 32'h8);
    imem_gnt = 1; tick();
    branch = 1; branch_target = 32'h10; tick();
    check("br if_valid a", {31'h0, if_valid}, 32'h0);
    tick();
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; tick();
    check("br discard if_valid", {31'h0, if_valid}, 32'h0);
    check("br next addr", imem_addr, 32'h10);
    fetch(32'h1234_5678);
    check("br if_pc", if_pc, 32'h10);
    check("br if_instr", if_instr, 32'h1234_5678);
    tick();

    // Jump beats branch in the grant cycle; target alignment.
    do_reset();
    imem_gnt = 1; branch = 1; branch_target = 32'h10; jump = 1; jump_target = 32'h20; tick();
    check("jb imem_req", {31'h0, imem_req}, 32'h0);
    imem_rvalid = 1; imem_rdata = 32'h1111_1111; tick();
    check("jb discard", {31'h0, if_valid}, 32'h0);
    check("jb addr", imem_addr, 32'h20);
    fetch(32'hCAFE_0020);
    check("jb if_pc", if_pc, 32'h20);
    jump = 1; jump_target = 32'h23; tick();
    check("jmp drop if_valid", {31'h0, if_valid}, 32'h0);
    check("jmp align addr", imem_addr, 32'h20);
    branch = 1; branch_target = 32'h41; tick();
    check("br req addr", imem_addr, 32'h40);

    // PC wrap on the instance reset to the top of the address space.
    do_reset();
    check("wrap first addr", imem_addr1, 32'hFFFF_FFFC);
    fetch(32'h5555_AAAA);
    check("wrap if_pc", if_pc1, 32'hFFFF_FFFC);
    check("wrap if_instr", if_instr1, 32'h5555_AAAA);
    tick();
    check("wrap next addr", imem_addr1, 32'h0);

    // Reset mid-fetch, stale rvalid afterwards.
    do_reset();
    fetch(32'h7777_0000); tick();
    imem_gnt = 1; tick();
    reset = 1; tick();
    reset = 0; imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0; tick();
    check("rst stale if_valid", {31'h0, if_valid}, 32'h0);
    check("rst stale pc", pc, RST_PC0);
    check("rst stale imem_req", {31'h0, imem_req}, 32'h1);
    fetch(32'h600D_0000);
    check("rst first if_pc", if_pc, RST_PC0);
    check("rst first if_instr", if_instr, 32'h600D_0000);
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
